// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper.
// Holds the controller state encoding and sweep dimensions.
package truth_table_sweeper_pkg;

    localparam int N_IN   = 5;
    localparam int N_COMB = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/truth_table_sweeper_popcount_acc.sv
// Six-bit ones accumulator with synchronous clear and enable.
// Ports: Clock, Resetn (sync, active-low), clr, en, inc -> count.
module popcount_acc (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       clr,
    input  logic       en,
    input  logic       inc,
    output logic [5:0] count
);

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            count <= 6'd0;
        end else if (clr) begin
            count <= 6'd0;
        end else if (en && inc) begin
            count <= count + 6'd1;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps a 5-input, 2-output function block through all 32 inputs,
// capturing truth tables, minterm counts and an expected-mask check.
// Ports: Clock, Resetn, Start, Hold, F_in, G_in in; X, Busy, Done,
// Valid, F_table, G_table, F_count, G_count, Pass, MisValid, MisIdx out.
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter logic [31:0] EXP_F    = 32'h00000000,
    parameter logic [31:0] EXP_G    = 32'h00000000,
    parameter bit          CHECK_EN = 1'b1
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Hold,
    output logic [N_IN-1:0]   X,
    input  logic              F_in,
    input  logic              G_in,
    output logic              Busy,
    output logic              Done,
    output logic              Valid,
    output logic [N_COMB-1:0] F_table,
    output logic [N_COMB-1:0] G_table,
    output logic [5:0]        F_count,
    output logic [5:0]        G_count,
    output logic              Pass,
    output logic              MisValid,
    output logic [N_IN-1:0]   MisIdx
);

    state_t          state;
    state_t          state_next;
    logic [N_IN-1:0] idx;
    logic            accept;
    logic            capture;
    logic            last;
    logic            mis_now;

    assign accept  = Start && (state == IDLE || state == DONE);
    assign capture = (state == SWEEP) && !Hold;
    assign last    = capture && (idx == 5'd31);

    // Compare is disabled entirely when CHECK_EN=0, so Pass ends up 1.
    assign mis_now = CHECK_EN &&
                     ((F_in != EXP_F[idx]) || (G_in != EXP_G[idx]));

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (Start) state_next = SWEEP;
            SWEEP:   if (last)  state_next = DONE;
            DONE:    if (Start) state_next = SWEEP;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy = (state == SWEEP);
        X    = Busy ? idx : '0;
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            idx      <= '0;
            F_table  <= '0;
            G_table  <= '0;
            MisValid <= 1'b0;
            MisIdx   <= '0;
            Pass     <= 1'b0;
            Valid    <= 1'b0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (accept) begin
                idx      <= '0;
                F_table  <= '0;
                G_table  <= '0;
                MisValid <= 1'b0;
                MisIdx   <= '0;
                Pass     <= 1'b0;
                Valid    <= 1'b0;
            end else if (capture) begin
                F_table[idx] <= F_in;
                G_table[idx] <= G_in;
                idx          <= idx + 5'd1;
                // First mismatch wins; later ones leave MisIdx alone.
                if (mis_now && !MisValid) begin
                    MisValid <= 1'b1;
                    MisIdx   <= idx;
                end
                if (last) begin
                    Done  <= 1'b1;
                    Valid <= 1'b1;
                    Pass  <= !(MisValid || mis_now);
                end
            end
        end
    end

    popcount_acc u_f_cnt (
        .Clock  (Clock),
        .Resetn (Resetn),
        .clr    (accept),
        .en     (capture),
        .inc    (F_in),
        .count  (F_count)
    );

    popcount_acc u_g_cnt (
        .Clock  (Clock),
        .Resetn (Resetn),
        .clr    (accept),
        .en     (capture),
        .inc    (G_in),
        .count  (G_count)
    );

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (checked and unchecked)
// driven by a table-lookup function block, compared to a sweep model.
module tb_truth_table_sweeper;

    localparam logic [31:0] EF1 = 32'hFFFF0000;
    localparam logic [31:0] EG1 = 32'h00000000;
    localparam logic [31:0] EF2 = 32'h12345678;
    localparam logic [31:0] EG2 = 32'h9ABCDEF0;

    logic Clock = 1'b0;
    logic Resetn = 1'b0;
    logic Start = 1'b0;
    logic Hold = 1'b0;
    logic [31:0] ftab = '0;
    logic [31:0] gtab = '0;

    logic [4:0]  x1, x2, mi1, mi2;
    logic        f1, g1, f2, g2;
    logic        busy1, done1, valid1, pass1, mv1;
    logic        busy2, done2, valid2, pass2, mv2;
    logic [31:0] ft1, gt1, ft2, gt2;
    logic [5:0]  fc1, gc1, fc2, gc2;

    int checks = 0;
    int errors = 0;

    assign f1 = ftab[x1];
    assign g1 = gtab[x1];
    assign f2 = ftab[x2];
    assign g2 = gtab[x2];

    always #5 Clock = ~Clock;

    truth_table_sweeper #(.EXP_F(EF1), .EXP_G(EG1), .CHECK_EN(1'b1)) dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .Hold(Hold),
        .X(x1), .F_in(f1), .G_in(g1), .Busy(busy1), .Done(done1),
        .Valid(valid1), .F_table(ft1), .G_table(gt1), .F_count(fc1),
        .G_count(gc1), .Pass(pass1), .MisValid(mv1), .MisIdx(mi1)
    );

    truth_table_sweeper #(.EXP_F(EF2), .EXP_G(EG2), .CHECK_EN(1'b0)) dut2 (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .Hold(Hold),
        .X(x2), .F_in(f2), .G_in(g2), .Busy(busy2), .Done(done2),
        .Valid(valid2), .F_table(ft2), .G_table(gt2), .F_count(fc2),
        .G_count(gc2), .Pass(pass2), .MisValid(mv2), .MisIdx(mi2)
    );

    // Sweep model: a sweep is "pos entries captured so far" of a
    // snapshot of the function tables; all outputs derive from that.
    bit          m_live = 0;
    bit          m_busy = 0;
    bit          m_valid = 0;
    bit          m_done = 0;
    int          m_pos = 0;
    logic [31:0] sf = '0;
    logic [31:0] sg = '0;

    function automatic logic [31:0] mask(input int p);
        logic [32:0] m;
        m = (33'd1 << p) - 33'd1;
        return m[31:0];
    endfunction

    function automatic int first_one(input logic [31:0] v);
        for (int i = 0; i < 32; i++) if (v[i]) return i;
        return 0;
    endfunction

    always @(posedge Clock) begin
        if (!Resetn) begin
            m_live  <= 1;
            m_busy  <= 0;
            m_valid <= 0;
            m_done  <= 0;
            m_pos   <= 0;
        end else begin
            m_done <= 0;
            if (!m_busy && Start) begin
                m_busy  <= 1;
                m_valid <= 0;
                m_pos   <= 0;
                sf      <= ftab;
                sg      <= gtab;
            end else if (m_busy && !Hold) begin
                m_pos <= m_pos + 1;
                if (m_pos == 31) begin
                    m_busy  <= 0;
                    m_valid <= 1;
                    m_done  <= 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (m_live) begin
            logic [31:0] mk, tf, tg, diff;
            mk   = mask(m_pos);
            tf   = sf & mk;
            tg   = sg & mk;
            diff = ((sf ^ EF1) | (sg ^ EG1)) & mk;
            chk("x",        x1,     m_busy ? m_pos : 0);
            chk("busy",     busy1,  m_busy);
            chk("done",     done1,  m_done);
            chk("valid",    valid1, m_valid);
            chk("ftab",     ft1,    tf);
            chk("gtab",     gt1,    tg);
            chk("fcnt",     fc1,    $countones(tf));
            chk("gcnt",     gc1,    $countones(tg));
            chk("misvalid", mv1,    diff != 0);
            chk("misidx",   mi1,    first_one(diff));
            chk("pass",     pass1,  m_valid && diff == 0);
            chk("x2",       x2,     m_busy ? m_pos : 0);
            chk("done2",    done2,  m_done);
            chk("ftab2",    ft2,    tf);
            chk("gcnt2",    gc2,    $countones(tg));
            chk("misvalid2", mv2,   0);
            chk("pass2",    pass2,  m_valid);
        end
    end

    task automatic tick();
        @(posedge Clock);
        #2;
    endtask

    task automatic sweep(input logic [31:0] f, input logic [31:0] g,
                         input int hold_at, input int hold_len,
                         input int poke_at, input int reset_at,
                         input int exp_lat, input bit rnd);
        int n;
        bit got;
        ftab  = f;
        gtab  = g;
        Start = 1;
        tick();
        Start = 0;
        chk("accept_valid", valid1, 0);
        chk("accept_ftab", ft1, 0);
        n   = 1;
        got = 0;
        while (n < 200 && !got) begin
            if (rnd) begin
                Hold  = ($urandom_range(0, 3) == 0);
                Start = (n < 25) && ($urandom_range(0, 7) == 0);
            end else begin
                Hold  = (hold_at >= 0) && (n > hold_at) &&
                        (n <= hold_at + hold_len);
                Start = (n == poke_at);
            end
            if (n == reset_at) Resetn = 0;
            tick();
            n++;
            Resetn = 1;
            if (reset_at >= 0 && n == reset_at + 1) begin
                Hold  = 0;
                Start = 0;
                chk("rst_x", x1, 0);
                chk("rst_busy", busy1, 0);
                chk("rst_ftab", ft1, 0);
                chk("rst_fcnt", fc1, 0);
                return;
            end
            if (done1) got = 1;
        end
        Hold  = 0;
        Start = 0;
        if (!got) chk("done_timeout", 0, 1);
        if (exp_lat > 0) chk("latency", n, exp_lat);
    endtask

    initial begin
        Resetn = 0;
        repeat (2) tick();
        Resetn = 1;
        tick();
        chk("reset_x", x1, 0);
        chk("reset_valid", valid1, 0);
        chk("reset_pass", pass1, 0);

        // f = x1, g = 0
        sweep(32'hFFFF0000, 32'h0, -1, 0, -1, -1, 33, 0);
        chk("basic_ftab", ft1, 32'hFFFF0000);
        chk("basic_fcnt", fc1, 16);
        chk("basic_gcnt", gc1, 0);
        chk("basic_pass", pass1, 1);
        chk("basic_mv", mv1, 0);

        // f = x5: restart from DONE, mismatch first at index 1
        sweep(32'hAAAAAAAA, 32'h0, -1, 0, -1, -1, 33, 0);
        chk("mis_ftab", ft1, 32'hAAAAAAAA);
        chk("mis_pass", pass1, 0);
        chk("mis_mv", mv1, 1);
        chk("mis_idx", mi1, 1);

        sweep(32'hFFFF0000, 32'h0, 10, 5, -1, -1, 38, 0);
        chk("hold_ftab", ft1, 32'hFFFF0000);

        sweep(32'hFFFF0000, 32'h0, -1, 0, 5, -1, 33, 0);

        sweep(32'hFFFF0000, 32'h0, -1, 0, -1, 21, 0, 0);
        sweep(32'hFFFF0000, 32'h0, -1, 0, -1, -1, 33, 0);
        chk("after_rst_ftab", ft1, 32'hFFFF0000);

        sweep(32'hFFFFFFFF, 32'hFFFFFFFF, -1, 0, -1, -1, 33, 0);
        chk("ones_fcnt", fc1, 32);
        chk("ones_gcnt", gc1, 32);
        chk("ones_gtab", gt1, 32'hFFFFFFFF);
        chk("ones_misidx", mi1, 0);
        chk("nochk_pass", pass2, 1);

        for (int k = 0; k < 8; k++) begin
            sweep($urandom, $urandom, -1, 0, -1, -1, 0, 1);
            repeat ($urandom_range(0, 3)) tick();
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
